mul_sequencer: RTL and testbench



---
 rtl/mul_sequencer_if.sv | 27 ++
 rtl/mul_sequencer.sv | 118 +++++++++++
 tb/tb_mul_sequencer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Handshake bundle between the EX stage and the multi-cycle MUL sequencer.
// EX drives the request side (Start/Flush/operands); the sequencer answers
// with the pipeline stall, its busy/done status and the product.
interface mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Flush;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Stall;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;

  // EX-stage side: issues MULs, consumes stall and result
  modport master (
    output Start, Flush, A, B,
    input  Stall, Busy, Done, Result
  );

  // Sequencer side
  modport slave (
    input  Start, Flush, A, B,
    output Stall, Busy, Done, Result
  );
endinterface

// File: rtl/mul_sequencer.sv
// Multi-cycle radix-2 shift-add sequencer for MUL in the EX stage.
// Accepts a MUL from IDLE, iterates WIDTH times in RUN while stalling the
// front of the pipe, then pulses Done for one cycle in DONE with the low
// WIDTH bits of the product on Result.
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  mul_sequencer_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] acc_sum;

  // Next-state and datapath: one shift-add iteration per RUN cycle
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    // Partial-product add; wraps mod 2^WIDTH, overflow intentionally dropped
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      S_IDLE: begin
        // A flush in the same cycle squashes the MUL before it is accepted
        if (bus.Start && !bus.Flush) begin
          mcand_d  = bus.A;
          mplier_d = bus.B;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.Flush) begin
          // Abort: Result keeps whatever the last completed MUL produced
          state_d = S_IDLE;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_d = acc_sum;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Start is still high for the MUL that is leaving EX; ignore it
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the upcoming state
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset clears everything immediately
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Stall covers the accept cycle plus every RUN cycle; it drops in DONE so
  // the MUL advances together with its Result. Held low while in reset.
  always_comb begin
    bus.Stall = !Reset &&
                (((state_q == S_IDLE) && bus.Start && !bus.Flush) ||
                 (state_q == S_RUN));
  end

  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Result = result_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Scoreboard bench for mul_sequencer: stimulus pushes expected products,
// a negedge monitor pops and compares whenever Done is seen.
module tb_mul_sequencer;

  logic Clk;
  logic Reset;

  mul_sequencer_if #(.WIDTH(32)) bus ();

  mul_sequencer #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding MUL
  always @(negedge Clk) begin
    if (Reset) begin
      prev_done <= 1'b0;
    end else begin
      if (bus.Done) begin
        check("done_single_cycle", 32'(prev_done), 32'd0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: Done=1 with no MUL outstanding, Result=0x%08h at %0t",
                   bus.Result, $time);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("result", bus.Result, e);
          $display("done: Result=0x%08h expected=0x%08h", bus.Result, e);
        end
      end
      prev_done <= bus.Done;
    end
  end

  // Issue one MUL starting now (caller is just past a rising edge); returns
  // just past the edge that ends the DONE cycle with Start lowered.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit scramble);
    int cyc;
    int stl;
    bit seen;
    $display("issue: A=0x%08h B=0x%08h expect=0x%08h scramble=%0d", a, b, exp, scramble);
    bus.Start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    exp_q.push_back(exp);
    cyc  = 0;
    stl  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge Clk);
      if (bus.Done) begin
        seen = 1'b1;
      end else begin
        cyc++;
        if (bus.Stall) stl++;
        if (cyc == 2) check("busy_in_run", 32'(bus.Busy), 32'd1);
        // Operands past the accept edge must not matter
        if (scramble && cyc > 1) begin
          bus.A = $urandom;
          bus.B = $urandom;
        end
      end
    end
    check("latency_cycles", cyc, 32'd33);
    check("stall_cycles", stl, 32'd33);
    if (seen) begin
      check("stall_in_done", 32'(bus.Stall), 32'd0);
      check("busy_in_done", 32'(bus.Busy), 32'd0);
    end
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
  endtask

  initial begin
    Reset     = 1'b1;
    bus.Start = 1'b1;   // must be ignored during reset
    bus.Flush = 1'b0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;

    repeat (2) @(negedge Clk);
    check("reset_stall", 32'(bus.Stall), 32'd0);
    check("reset_busy", 32'(bus.Busy), 32'd0);
    check("reset_done", 32'(bus.Done), 32'd0);
    check("reset_result", bus.Result, 32'd0);
    @(posedge Clk);
    #1;
    Reset     = 1'b0;
    bus.Start = 1'b0;
    @(posedge Clk);
    #1;

    // Basic products and overflow boundaries
    issue(32'd7,          32'd6,  32'h0000_002A, 1'b0);
    issue(32'hFFFF_FFFF,  32'd5,  32'hFFFF_FFFB, 1'b0);
    issue(32'h8000_0000,  32'd2,  32'h0000_0000, 1'b0);
    issue(32'h1234_5678,  32'd9,  32'hA3D7_0A38, 1'b0);
    issue(32'hDEAD_BEEF,  32'd0,  32'h0000_0000, 1'b0);
    // Operand changes during RUN ignored
    issue(32'd3,          32'd4,  32'h0000_000C, 1'b1);
    // Back-to-back pair (second MUL in EX during the IDLE cycle after DONE)
    issue(32'd5,          32'd5,  32'h0000_0019, 1'b0);
    issue(32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b0);

    // Start and Flush together in IDLE: no acceptance
    @(posedge Clk);
    #1;
    bus.Start = 1'b1;
    bus.Flush = 1'b1;
    bus.A     = 32'd2;
    bus.B     = 32'd2;
    @(negedge Clk);
    check("flush_idle_stall", 32'(bus.Stall), 32'd0);
    @(posedge Clk);
    #1;
    bus.Start = 1'b0;
    bus.Flush = 1'b0;
    @(negedge Clk);
    check("flush_idle_busy", 32'(bus.Busy), 32'd0);

    // Establish a known prior Result, then flush in the 10th RUN cycle
    @(posedge Clk);
    #1;
    issue(32'd7, 32'd6, 32'h0000_002A, 1'b0);
    $display("flush: A=0x0000000b B=0x0000000d aborted in RUN cycle 10");
    bus.Start = 1'b1;
    bus.A     = 32'd11;
    bus.B     = 32'd13;
    repeat (11) @(negedge Clk);
    check("busy_before_flush", 32'(bus.Busy), 32'd1);
    bus.Flush = 1'b1;
    @(posedge Clk);
    #1;
    bus.Flush = 1'b0;
    bus.Start = 1'b0;
    @(negedge Clk);
    check("flush_run_stall", 32'(bus.Stall), 32'd0);
    check("flush_run_busy", 32'(bus.Busy), 32'd0);
    check("flush_run_done", 32'(bus.Done), 32'd0);
    check("flush_run_result", bus.Result, 32'h0000_002A);
    repeat (40) @(negedge Clk);
    check("flush_result_held", bus.Result, 32'h0000_002A);

    // Asynchronous reset between edges in the middle of RUN
    @(posedge Clk);
    #1;
    $display("reset: A=0x00000055 B=0x00000003 aborted by async reset");
    bus.Start = 1'b1;
    bus.A     = 32'h55;
    bus.B     = 32'd3;
    repeat (6) @(negedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_busy", 32'(bus.Busy), 32'd0);
    check("async_rst_done", 32'(bus.Done), 32'd0);
    check("async_rst_result", bus.Result, 32'd0);
    check("async_rst_stall", 32'(bus.Stall), 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    issue(32'd9, 32'd9, 32'h0000_0051, 1'b0);

    repeat (3) @(negedge Clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
